// File: rtl/seconds_counter_pkg.sv
// Shared definitions for the stopwatch seconds stage: state encodings, widths
// and the start_stop transition rule.
package seconds_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int SEC_W       = 6;
    localparam int SEC_MAX_DEF = 59;
    localparam int DIV_DEF     = 100_000_000;

    // Run/pause toggle; anything that is not RUN or PAUSE (IDLE) starts running.
    function automatic state_t toggle_state(input state_t s);
        case (s)
            ST_RUN:  toggle_state = ST_PAUSE;
            default: toggle_state = ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/seconds_counter_if.sv
// Control/status bundle between the stopwatch front panel and the seconds stage.
interface seconds_counter_if;
    import seconds_counter_pkg::*;

    // start_stop and clear are single-cycle pulses sampled on every rising edge
    // (no valid/ready: each high cycle is one command). Outputs are registered.
    logic             start_stop;
    logic             clear;
    logic [SEC_W-1:0] secs;
    logic             oflow_s;
    logic             running;
    state_t           state;

    modport master (
        output start_stop, clear,
        input  secs, oflow_s, running, state
    );

    modport slave (
        input  start_stop, clear,
        output secs, oflow_s, running, state
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV enabled cycles; holds while
// disabled and restarts from zero when zero is asserted.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic zero,
    output logic tick
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;

    assign tick = en && !zero && (presc == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (zero) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
        end
    end

endmodule

// File: rtl/seconds_counter.sv
// Seconds stage of the stopwatch: run/pause/clear FSM, 0..SEC_MAX counter and
// a one-cycle overflow pulse that feeds the minutes stage.
module seconds_counter
    import seconds_counter_pkg::*;
#(
    parameter int DIV     = DIV_DEF,
    parameter int SEC_MAX = SEC_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    seconds_counter_if.slave   bus
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);

    state_t           state_q;
    logic [SEC_W-1:0] secs_q;
    logic             oflow_q;
    logic             running_q;
    logic             tick;
    logic             presc_en;
    logic             presc_zero;

    // Prescaler holds in PAUSE and is forced to zero in IDLE (or any stray encoding).
    assign presc_en   = (state_q == ST_RUN);
    assign presc_zero = bus.clear || !((state_q == ST_RUN) || (state_q == ST_PAUSE));

    tick_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .zero (presc_zero),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            secs_q    <= '0;
            oflow_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            oflow_q <= 1'b0;
            if (bus.clear) begin
                // Clear wins over a coincident tick and start_stop.
                state_q   <= ST_IDLE;
                secs_q    <= '0;
                running_q <= 1'b0;
            end else begin
                if (tick) begin
                    if (secs_q == SEC_LAST) begin
                        secs_q  <= '0;
                        oflow_q <= 1'b1;
                    end else begin
                        secs_q <= secs_q + 1'b1;
                    end
                end
                case (state_q)
                    ST_IDLE, ST_RUN, ST_PAUSE: begin
                        if (bus.start_stop) begin
                            state_q   <= toggle_state(state_q);
                            running_q <= (toggle_state(state_q) == ST_RUN);
                        end else begin
                            running_q <= (state_q == ST_RUN);
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        secs_q    <= '0;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.secs    = secs_q;
    assign bus.oflow_s = oflow_q;
    assign bus.running = running_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_seconds_counter.sv
// Bench for the seconds stage with a behavioural minutes stage downstream and
// an arithmetic reference model of elapsed run cycles.
module tb_seconds_counter;

    localparam int DIV     = 4;
    localparam int SEC_MAX = 59;
    localparam int PERIOD  = DIV * (SEC_MAX + 1);

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    seconds_counter_if sc_if ();

    seconds_counter #(.DIV(DIV), .SEC_MAX(SEC_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sc_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- minutes stage ----------------
    int minutes;
    always @(posedge clk or posedge rst) begin
        if (rst) minutes <= 0;
        else     minutes <= minutes + int'(sc_if.oflow_s);
    end

    // ---------------- reference model ----------------
    // Seconds are derived from the number of RUN cycles since the last clear.
    int         m_state   = 0;  // 0 idle, 1 run, 2 pause
    int         run_edges = 0;
    int         m_min     = 0;
    logic       m_oflow   = 1'b0;
    logic [5:0] exp_secs  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state   = 0;
            run_edges = 0;
            m_min     = 0;
            m_oflow   = 1'b0;
        end else begin
            if (m_oflow) m_min++;
            m_oflow = 1'b0;
            if (sc_if.clear) begin
                run_edges = 0;
                m_state   = 0;
            end else begin
                if (m_state == 1) begin
                    run_edges++;
                    if (run_edges % PERIOD == 0) m_oflow = 1'b1;
                end
                if (sc_if.start_stop) m_state = (m_state == 1) ? 2 : 1;
            end
        end
        exp_secs = 6'((run_edges / DIV) % (SEC_MAX + 1));
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic ss, input logic clr);
        sc_if.start_stop = ss;
        sc_if.clear      = clr;
        @(posedge clk);
        @(negedge clk);
        sc_if.start_stop = 1'b0;
        sc_if.clear      = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sc_if.secs, sc_if.oflow_s, sc_if.running} !== 8'b0)
            $display("FAIL reset_hold got secs=%0d oflow=%0b run=%0b exp 0/0/0",
                     sc_if.secs, sc_if.oflow_s, sc_if.running);
        else n_pass++;
        rst = 1'b0;
        repeat (50) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if ({sc_if.secs, sc_if.oflow_s, sc_if.running, sc_if.state} !== 10'b0)
                $display("FAIL reset_idle t=%0t got secs=%0d oflow=%0b run=%0b st=%0d exp 0/0/0/0",
                         $time, sc_if.secs, sc_if.oflow_s, sc_if.running, sc_if.state);
            else n_pass++;
        end
    endtask

    task automatic test_count();
        int pulses = 0;
        cycle(1'b1, 1'b0);
        n_checks++;
        if (sc_if.running !== 1'b1 || sc_if.secs !== 6'd0)
            $display("FAIL count_start got run=%0b secs=%0d exp 1/0", sc_if.running, sc_if.secs);
        else n_pass++;
        repeat (2 * PERIOD) begin
            cycle(1'b0, 1'b0);
            if (sc_if.oflow_s === 1'b1) pulses++;
            n_checks++;
            if ({sc_if.secs, sc_if.oflow_s, sc_if.running} !== {exp_secs, m_oflow, m_state == 1})
                $display("FAIL count t=%0t got secs=%0d oflow=%0b run=%0b exp %0d/%0b/%0b",
                         $time, sc_if.secs, sc_if.oflow_s, sc_if.running, exp_secs, m_oflow, m_state == 1);
            else n_pass++;
            n_checks++;
            if (minutes !== m_min)
                $display("FAIL count_minutes t=%0t got %0d exp %0d", $time, minutes, m_min);
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 2) $display("FAIL count_pulses got %0d exp 2", pulses);
        else n_pass++;
        cycle(1'b0, 1'b0);
        n_checks++;
        if (minutes !== 2) $display("FAIL count_minutes_final got %0d exp 2", minutes);
        else n_pass++;
    endtask

    task automatic test_pause_resume();
        int guard = 0;
        while (!(exp_secs == 6'd7 && run_edges % DIV == 2 && m_state == 1) && guard < 2 * PERIOD) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 2 * PERIOD) $display("FAIL pause_reach got timeout exp secs=7 presc=2");
        else n_pass++;
        cycle(1'b1, 1'b0);
        repeat (10) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if (sc_if.secs !== 6'd7 || sc_if.running !== 1'b0 || sc_if.state !== 2'd2)
                $display("FAIL pause_hold got secs=%0d run=%0b st=%0d exp 7/0/2",
                         sc_if.secs, sc_if.running, sc_if.state);
            else n_pass++;
        end
        cycle(1'b1, 1'b0);
        n_checks++;
        if (sc_if.secs !== 6'd7 || sc_if.running !== 1'b1)
            $display("FAIL resume_edge got secs=%0d run=%0b exp 7/1", sc_if.secs, sc_if.running);
        else n_pass++;
        cycle(1'b0, 1'b0);
        n_checks++;
        if (sc_if.secs !== 6'd8) $display("FAIL resume_tick got secs=%0d exp 8", sc_if.secs);
        else n_pass++;
    endtask

    task automatic test_clear_with_start();
        int guard = 0;
        int min_before;
        while (!(exp_secs == 6'd59 && run_edges % DIV == DIV - 1) && guard < 2 * PERIOD) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 2 * PERIOD) $display("FAIL clear_reach got timeout exp secs=59 presc=3");
        else n_pass++;
        min_before = m_min;
        cycle(1'b1, 1'b1);
        n_checks++;
        if ({sc_if.secs, sc_if.oflow_s, sc_if.running, sc_if.state} !== 10'b0)
            $display("FAIL clear_coincident got secs=%0d oflow=%0b run=%0b st=%0d exp 0/0/0/0",
                     sc_if.secs, sc_if.oflow_s, sc_if.running, sc_if.state);
        else n_pass++;
        repeat (3) cycle(1'b0, 1'b0);
        n_checks++;
        if (minutes !== min_before || sc_if.secs !== 6'd0)
            $display("FAIL clear_minutes got min=%0d secs=%0d exp %0d/0", minutes, sc_if.secs, min_before);
        else n_pass++;
        cycle(1'b0, 1'b1);
        n_checks++;
        if (sc_if.state !== 2'd0 || sc_if.secs !== 6'd0)
            $display("FAIL clear_idle_noop got st=%0d secs=%0d exp 0/0", sc_if.state, sc_if.secs);
        else n_pass++;
    endtask

    task automatic test_wrap_into_pause();
        int guard = 0;
        int min_before;
        cycle(1'b1, 1'b0);
        while (!(exp_secs == 6'd59 && run_edges % DIV == DIV - 1) && guard < 2 * PERIOD) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 2 * PERIOD) $display("FAIL wrap_reach got timeout exp secs=59 presc=3");
        else n_pass++;
        min_before = m_min;
        cycle(1'b1, 1'b0);
        n_checks++;
        if (sc_if.secs !== 6'd0 || sc_if.oflow_s !== 1'b1 || sc_if.running !== 1'b0 || sc_if.state !== 2'd2)
            $display("FAIL wrap_pause got secs=%0d oflow=%0b run=%0b st=%0d exp 0/1/0/2",
                     sc_if.secs, sc_if.oflow_s, sc_if.running, sc_if.state);
        else n_pass++;
        cycle(1'b0, 1'b0);
        n_checks++;
        if (sc_if.oflow_s !== 1'b0 || minutes !== min_before + 1)
            $display("FAIL wrap_minutes got oflow=%0b min=%0d exp 0/%0d", sc_if.oflow_s, minutes, min_before + 1);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int guard = 0;
        cycle(1'b1, 1'b0);
        while (exp_secs != 6'd30 && guard < 2 * PERIOD) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        n_checks++;
        if (guard >= 2 * PERIOD || sc_if.secs !== 6'd30)
            $display("FAIL areset_reach got secs=%0d exp 30", sc_if.secs);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({sc_if.secs, sc_if.oflow_s, sc_if.running} !== 8'b0)
            $display("FAIL areset_immediate got secs=%0d oflow=%0b run=%0b exp 0/0/0",
                     sc_if.secs, sc_if.oflow_s, sc_if.running);
        else n_pass++;
        #1 rst = 1'b0;
        @(negedge clk);
        repeat (10) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if (sc_if.secs !== 6'd0 || sc_if.running !== 1'b0)
                $display("FAIL areset_stays_idle got secs=%0d run=%0b exp 0/0", sc_if.secs, sc_if.running);
            else n_pass++;
        end
        cycle(1'b1, 1'b0);
        repeat (12) begin
            cycle(1'b0, 1'b0);
            n_checks++;
            if ({sc_if.secs, sc_if.running} !== {exp_secs, m_state == 1})
                $display("FAIL areset_restart got secs=%0d run=%0b exp %0d/%0b",
                         sc_if.secs, sc_if.running, exp_secs, m_state == 1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic ss;
        logic clr;
        repeat (1500) begin
            ss  = ($urandom_range(0, 24) == 0);
            clr = ($urandom_range(0, 299) == 0);
            cycle(ss, clr);
            n_checks++;
            if ({sc_if.secs, sc_if.oflow_s, sc_if.running, sc_if.state} !==
                {exp_secs, m_oflow, m_state == 1, 2'(m_state)})
                $display("FAIL random t=%0t got secs=%0d oflow=%0b run=%0b st=%0d exp %0d/%0b/%0b/%0d",
                         $time, sc_if.secs, sc_if.oflow_s, sc_if.running, sc_if.state,
                         exp_secs, m_oflow, m_state == 1, m_state);
            else n_pass++;
            n_checks++;
            if (minutes !== m_min)
                $display("FAIL random_minutes t=%0t got %0d exp %0d", $time, minutes, m_min);
            else n_pass++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks         = 0;
        n_pass           = 0;
        rst              = 1'b1;
        sc_if.start_stop = 1'b0;
        sc_if.clear      = 1'b0;
        @(negedge clk);
        test_reset();
        test_count();
        test_pause_resume();
        test_clear_with_start();
        test_wrap_into_pause();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
